// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial BCD to Excess-3 encoder.
// Adds the constant 0011 to a 4-bit LSB-first digit, one accepted bit per cycle.
// The serial result leaves one registered cycle later. When the 4th bit is
// accepted, the complete code and a non-BCD flag are published in parallel.
// The adder is a 7-state Mealy machine. Each state encodes the bit position and
// the carry into that position. Bit 0 has no carry, so it has only one state.
module bcd_to_excess3_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       digit_done,
  output logic [3:0] e3_digit,
  output logic       bad_digit
);

  typedef enum logic [2:0] {
    StB0,
    StB1C0,
    StB1C1,
    StB2C0,
    StB2C1,
    StB3C0,
    StB3C1
  } state_e;

  state_e     state_q;
  state_e     state_d;
  logic       sum_bit;
  logic       last_bit;

  // Output bits of the digit so far; bit 0 is the oldest.
  logic [2:0] out_sh_q;
  // Input bits of the digit so far; needed for the non-BCD check.
  logic [2:0] in_sh_q;

  // Serial adder step.
  // This block gives the sum bit and the next position/carry state for the current in_bit.
  // The constant bits are k0=1, k1=1, k2=0 and k3=0.
  always_comb begin
    sum_bit  = 1'b0;
    state_d  = StB0;
    last_bit = 1'b0;
    case (state_q)
      StB0: begin
        // k=1, carry=0: sum=~x, carry-out=x
        sum_bit = ~in_bit;
        state_d = in_bit ? StB1C1 : StB1C0;
      end
      StB1C0: begin
        // k=1, carry=0
        sum_bit = ~in_bit;
        state_d = in_bit ? StB2C1 : StB2C0;
      end
      StB1C1: begin
        // k=1, carry=1: carry-out is always 1
        sum_bit = in_bit;
        state_d = StB2C1;
      end
      StB2C0: begin
        // k=0, carry=0: no carry can be generated
        sum_bit = in_bit;
        state_d = StB3C0;
      end
      StB2C1: begin
        // k=0, carry=1: carry-out=x
        sum_bit = ~in_bit;
        state_d = in_bit ? StB3C1 : StB3C0;
      end
      StB3C0: begin
        // The carry out of bit 3 is dropped, so the sum wraps modulo 16.
        sum_bit  = in_bit;
        state_d  = StB0;
        last_bit = 1'b1;
      end
      StB3C1: begin
        sum_bit  = ~in_bit;
        state_d  = StB0;
        last_bit = 1'b1;
      end
      default: begin
        sum_bit  = 1'b0;
        state_d  = StB0;
        last_bit = 1'b0;
      end
    endcase
  end

  // FSM state update and the registered serial output.
  // When in_valid is low, the state and out_bit hold their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StB0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_q <= state_d;
        out_bit <= sum_bit;
      end
    end
  end

  // Digit assembly.
  // This block shifts in the partial bits and publishes the parallel code and flag on the 4th bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sh_q   <= 3'b000;
      in_sh_q    <= 3'b000;
      digit_done <= 1'b0;
      e3_digit   <= 4'b0000;
      bad_digit  <= 1'b0;
    end else begin
      digit_done <= in_valid & last_bit;
      if (in_valid) begin
        if (last_bit) begin
          e3_digit  <= {sum_bit, out_sh_q};
          // Codes 10-15 are the ones with b3 set and either b2 or b1 set.
          bad_digit <= in_bit & (in_sh_q[2] | in_sh_q[1]);
        end else begin
          out_sh_q <= {sum_bit, out_sh_q[2:1]};
          in_sh_q  <= {in_bit, in_sh_q[2:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Self-checking bench for bcd_to_excess3_serial.
// It runs directed test-plan sequences, then random traffic against an arithmetic model.
module tb_bcd_to_excess3_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       out_valid;
  logic       out_bit;
  logic       digit_done;
  logic [3:0] e3_digit;
  logic       bad_digit;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  int unsigned m_cnt  = 0;    // accepted bits in the current digit
  int unsigned m_acc  = 0;    // value of the accepted bits so far
  logic        m_ov   = 1'b0;
  logic        m_ob   = 1'b0;
  logic        m_done = 1'b0;
  logic [3:0]  m_e3   = 4'd0;
  logic        m_bad  = 1'b0;

  int unsigned dones = 0;     // digit_done pulses observed

  bcd_to_excess3_serial dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .out_valid  (out_valid),
    .out_bit    (out_bit),
    .digit_done (digit_done),
    .e3_digit   (e3_digit),
    .bad_digit  (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // The model advances one clock using the inputs present at the edge.
  task automatic model_edge(input logic v, input logic b, input logic r);
    int unsigned e3_full;
    if (r) begin
      m_cnt = 0; m_acc = 0; m_ov = 0; m_ob = 0; m_done = 0; m_e3 = 0; m_bad = 0;
    end else begin
      m_ov   = v;
      m_done = 1'b0;
      if (v) begin
        m_acc = m_acc + (32'(b) << m_cnt);
        // The low bits of a sum depend only on the low bits of its operands.
        e3_full = m_acc + 3;
        m_ob    = e3_full[m_cnt];
        if (m_cnt == 3) begin
          m_done = 1'b1;
          m_e3   = 4'(e3_full);
          m_bad  = (m_acc > 9);
          m_cnt  = 0;
          m_acc  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) check("out_bit", 32'(out_bit), 32'(m_ob));
    check("digit_done", 32'(digit_done), 32'(m_done));
    check("e3_digit", 32'(e3_digit), 32'(m_e3));
    check("bad_digit", 32'(bad_digit), 32'(m_bad));
    if (digit_done) dones++;
  endtask

  // One clock: drive the inputs, take the edge, then sample 1 time unit later.
  task automatic step(input logic v, input logic b, input logic r);
    in_valid = v;
    in_bit   = b;
    rst      = r;
    @(posedge clk);
    model_edge(v, b, r);
    #1;
    compare_all();
  endtask

  task automatic send_digit(input int unsigned d);
    for (int i = 0; i < 4; i++) step(1'b1, d[i], 1'b0);
  endtask

  task automatic stall(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0]  stream;
  int unsigned d0;

  initial begin
    in_valid = 1'b0;
    in_bit   = 1'b0;
    rst      = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    // Reset wins over a valid bit in the same cycle.
    step(1'b1, 1'b1, 1'b1);
    check("reset_e3", 32'(e3_digit), 32'd0);
    check("reset_ov", 32'(out_valid), 32'd0);

    // Digit 0: the out bits are 1,1,0,0.
    stream = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      stream[i] = out_bit;
    end
    check("d0_stream", 32'(stream[3:0]), 32'b0011);
    check("d0_e3", 32'(e3_digit), 32'b0011);
    check("d0_done", 32'(digit_done), 32'd1);

    // Sweep the digits 0-9 back-to-back.
    d0 = dones;
    for (int d = 0; d < 10; d++) begin
      send_digit(d);
      check("sweep_e3", 32'(e3_digit), 32'(d + 3));
    end
    check("sweep_dones", dones - d0, 32'd10);

    // Digit 5 with stalls in the middle.
    stream = 8'd0;
    step(1'b1, 1'b1, 1'b0); stream[0] = out_bit;
    step(1'b1, 1'b0, 1'b0); stream[1] = out_bit;
    stall(3);
    step(1'b1, 1'b1, 1'b0); stream[2] = out_bit;
    stall(1);
    step(1'b1, 1'b0, 1'b0); stream[3] = out_bit;
    check("d5_stream", 32'(stream[3:0]), 32'b1000);
    check("d5_e3", 32'(e3_digit), 32'b1000);

    // Invalid digits, then a valid digit.
    send_digit(12);
    check("d12_e3", 32'(e3_digit), 32'b1111);
    check("d12_bad", 32'(bad_digit), 32'd1);
    send_digit(13);
    check("d13_e3", 32'(e3_digit), 32'b0000);
    send_digit(4);
    check("d4_e3", 32'(e3_digit), 32'b0111);
    check("d4_bad", 32'(bad_digit), 32'd0);

    // Reset after 2 bits of digit 7, then send digit 2.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    d0 = dones;
    send_digit(2);
    check("abort_dones", dones - d0, 32'd1);
    check("abort_e3", 32'(e3_digit), 32'b0101);

    // Digits 2 then 7 back-to-back.
    stream = 8'd0;
    for (int i = 0; i < 8; i++) begin
      d0 = (i < 4) ? 2 : 7;
      step(1'b1, d0[i % 4], 1'b0);
      stream[i] = out_bit;
      if (i == 3) check("b2b_e3a", 32'(e3_digit), 32'b0101);
    end
    check("b2b_e3b", 32'(e3_digit), 32'b1010);
    // The first out bit sits at stream[0]: the sequence 1,0,1,0,0,1,0,1 reads 8'b10100101.
    check("b2b_stream", 32'(stream), 32'b10100101);

    // Random traffic with occasional stalls and resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(99) == 0));
    end
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_excess3_serial.md
# bcd_to_excess3_serial

Bit-serial BCD-to-Excess-3 encoder. It accepts one BCD digit as 4 consecutive LSB-first bits and emits the Excess-3 code (digit + 3) bit-by-bit, one registered cycle later. It also presents the completed 4-bit code in parallel and flags non-BCD input (10–15). It feeds serial links whose far end decodes Excess-3 back to BCD.

## Interface
- No parameters; digit width fixed at 4 bits, offset fixed at 3 (0011).
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_bit is valid this cycle; an input bit is consumed on every clock edge where in_valid=1
- in_bit  input  1  serial BCD bit, LSB first, 4 accepted bits per digit
- out_valid  output  1  out_bit valid this cycle
- out_bit  output  1  serial Excess-3 bit, LSB first
- digit_done  output  1  one-cycle pulse coinciding with out_valid of the 4th output bit of a digit
- e3_digit  output  4  parallel Excess-3 code of the last completed digit; holds until the next digit completes
- bad_digit  output  1  valid with digit_done; 1 if the completed input digit was 10–15. Holds with e3_digit.

## Operation
- The datapath is a serial adder of the constant 0011, LSB first: k0=1, k1=1, k2=0, k3=0. Sum = in_bit ^ k ^ carry. Carry-out = majority(in_bit, k, carry).
- Mealy FSM, 7 states, advancing only when in_valid=1:
  - B0: emit ~x; go to B1_C(x)
  - B1_Cc: emit ~(x^c); go to B2_C(x|c)
  - B2_Cc: emit x^c; go to B3_C(x&c)
  - B3_Cc: emit x^c; go to B0; the carry out of bit 3 is discarded (mod-16)
- An equivalent implementation is a 2-bit position counter plus a carry flop. Its observable behaviour must be identical.
- A 4-bit shift register collects output bits.
  - At the 4th accepted bit, e3_digit is loaded with the complete code: bit 0 = first output bit.
  - bad_digit is loaded with b3 & (b2 | b1) of the input digit. The input bits are captured alongside.
- Invalid digits are still encoded mod 16 (12→1111, 13→0000, 15→0010). bad_digit is the only indication.
- in_valid=0 (stall): FSM, carry, and partial registers hold. out_valid=0 and digit_done=0 the next cycle. A stall of any length mid-digit must not change the result.
- Digits are back-to-back with no gap required. Bit 0 of the next digit may be accepted the cycle after bit 3.
- No backpressure: the block always accepts input.

## Timing
- Latency: in_bit accepted at edge N appears as out_bit with out_valid=1 during the cycle after edge N. It is fully registered, with no combinational path from input to output.
- out_valid equals in_valid delayed by one cycle.
- digit_done, e3_digit, and bad_digit update on the same edge as the 4th out_bit. digit_done is high for exactly one cycle.
- Throughput: 1 bit/cycle sustained, i.e. 1 digit per 4 cycles.
- Reset values: state=B0, carry=0, out_valid=0, out_bit=0, digit_done=0, e3_digit=0000, bad_digit=0.
- Reset mid-digit: the partial digit is discarded and no digit_done is issued for it. The next accepted bit is treated as bit 0.
- Reset with in_valid=1 in the same cycle: reset wins and the bit is not consumed.

## Test plan
- Digit 0 (in bits 0,0,0,0) → out bits 1,1,0,0; e3_digit=0011; bad_digit=0; digit_done on the 4th out_valid cycle.
- Sweep 0–9 back-to-back with in_valid held at 1 → e3_digit = d+3 for each digit (9 → 1100, out 0,0,1,1). digit_done every 4 cycles; bad_digit always 0.
- Digit 5 with in_valid low for 3 cycles after bit 1 and 1 cycle after bit 2 → out bits 0,0,0,1; e3_digit=1000; no out_valid during stalls.
- Invalid digits: 12 → e3_digit=1111, bad_digit=1. 13 → 0000, bad_digit=1. Then digit 4 → 0111, bad_digit=0.
- Reset after 2 bits of digit 7, then digit 2 → no digit_done for the aborted digit; e3_digit=0101 for digit 2.
- Back-to-back 2 then 7 → out stream 1,0,1,0,0,1,0,1. e3_digit is 0101, then 1010 on consecutive digit_done pulses 4 cycles apart.
